// File: rtl/pio_gpio_irq.sv
// Avalon-MM GPIO with set/clear output ports, direction control, a two-flop input
// synchroniser, per-bit edge capture and a maskable level interrupt.

module pio_gpio_bit #(
    parameter logic RESET_BIT = 1'b0,
    parameter int   EDGE_TYPE = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    input  logic wd,
    input  logic wr_data,
    input  logic wr_dir,
    input  logic wr_mask,
    input  logic wr_cap,
    input  logic wr_set,
    input  logic wr_clr,
    output logic out,
    output logic dir,
    output logic mask,
    output logic cap,
    output logic sync
);
    logic sync1, sync2, prev, edge_hit;

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_hit = sync2 & ~prev;
            1:       edge_hit = ~sync2 & prev;
            default: edge_hit = sync2 ^ prev;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            out   <= RESET_BIT;
            dir   <= 1'b0;
            mask  <= 1'b0;
            cap   <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            prev  <= sync2;
            if (wr_data)
                out <= wd;
            else if (wr_set && wd)
                out <= 1'b1;
            else if (wr_clr && wd)
                out <= 1'b0;
            if (wr_dir)
                dir <= wd;
            if (wr_mask)
                mask <= wd;
            // A fresh edge overrides a simultaneous write-1-to-clear.
            cap <= (cap & ~(wr_cap & wd)) | edge_hit;
        end
    end

    assign sync = sync2;
endmodule

module pio_gpio_irq #(
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);
    logic                  wr;
    logic                  wr_data, wr_dir, wr_mask, wr_cap, wr_set, wr_clr;
    logic [DATA_WIDTH-1:0] wd, dir, mask, cap, sync;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;

    assign wr_data = wr && (address == 3'd0);
    assign wr_dir  = wr && (address == 3'd1);
    assign wr_mask = wr && (address == 3'd2);
    assign wr_cap  = wr && (address == 3'd3);
    assign wr_set  = wr && (address == 3'd4);
    assign wr_clr  = wr && (address == 3'd5);

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        pio_gpio_bit #(
            .RESET_BIT (RESET_VALUE[i]),
            .EDGE_TYPE (EDGE_TYPE)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .wd      (wd[i]),
            .wr_data (wr_data),
            .wr_dir  (wr_dir),
            .wr_mask (wr_mask),
            .wr_cap  (wr_cap),
            .wr_set  (wr_set),
            .wr_clr  (wr_clr),
            .out     (out_port[i]),
            .dir     (dir[i]),
            .mask    (mask[i]),
            .cap     (cap[i]),
            .sync    (sync[i])
        );
    end

    // Zero-wait-state read path; OUTSET/OUTCLEAR and unused words read back 0.
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = sync;
            3'd1:    rd_mux = dir;
            3'd2:    rd_mux = mask;
            3'd3:    rd_mux = cap;
            default: rd_mux = '0;
        endcase
    end

    assign readdata = 32'(rd_mux);
    assign oe       = dir;
    assign irq      = |(cap & mask);
endmodule
